// File: rtl/regfile_wr_arbiter_pkg.sv
// rtl/regfile_wr_arbiter_pkg.sv - shared widths and arbiter state encodings
package regfile_wr_arbiter_pkg;

    localparam int REG_DATA_SIZE = 32;
    localparam int REG_ADDR_SIZE = 5;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - writeback (A) and late-unit (B) request handshakes
interface regfile_wr_arbiter_if
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DATA_W = REG_DATA_SIZE,
    parameter int ADDR_W = REG_ADDR_SIZE
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_addr;
    logic [DATA_W-1:0] lu_data;

    modport master (
        output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
        input  wb_ready, lu_ready
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
        output wb_ready, lu_ready
    );
endinterface

// File: rtl/regfile_wr_fifo.sv
// rtl/regfile_wr_fifo.sv - late-unit write FIFO exposing every entry address and valid bit
module regfile_wr_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    output logic [DEPTH-1:0]             entry_valid
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]                wr_ptr;
    logic [PTR_W:0]                rd_ptr;
    logic [PTR_W-1:0]              wr_idx;
    logic [PTR_W-1:0]              rd_idx;
    logic [DEPTH-1:0][ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]             mem_data [DEPTH];
    logic [DEPTH-1:0]              valid;

    assign wr_idx = wr_ptr[PTR_W-1:0];
    assign rd_idx = rd_ptr[PTR_W-1:0];

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);

    assign head_addr   = mem_addr[rd_idx];
    assign head_data   = mem_data[rd_idx];
    assign entry_addr  = mem_addr;
    assign entry_valid = valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            valid    <= '0;
            mem_addr <= '0;
        end else begin
            if (push) begin
                mem_addr[wr_idx] <= push_addr;
                valid[wr_idx]    <= 1'b1;
                wr_ptr           <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                valid[rd_idx] <= 1'b0;
                rd_ptr        <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_idx] <= push_data;
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - register-file write port arbiter, writeback over queued late-unit writes
// Optional statistics counters: REGWR_ARB_STATS_EN
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DATA_W        = REG_DATA_SIZE,
    parameter int ADDR_W        = REG_ADDR_SIZE,
    parameter int LU_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_wr_arbiter_if.slave      bus,
    output logic [(1<<ADDR_W)-1:0]   pending_mask,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
`ifdef REGWR_ARB_STATS_EN
    output logic                     wr_enable,
    output logic [15:0]              stat_conflicts,
    output logic [15:0]              stat_forced
`else
    output logic                     wr_enable
`endif
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_t                              state;
    arb_state_t                              state_next;
    logic [7:0]                              starve_cnt;
    logic [7:0]                              starve_next;
    logic                                    force_b;
    logic                                    grant_a;
    logic                                    grant_b;
    logic                                    fifo_push;
    logic                                    fifo_full;
    logic                                    fifo_empty;
    logic [ADDR_W-1:0]                       head_addr;
    logic [DATA_W-1:0]                       head_data;
    logic [LU_FIFO_DEPTH-1:0][ADDR_W-1:0]    entry_addr;
    logic [LU_FIFO_DEPTH-1:0]                entry_valid;

    assign bus.lu_ready = !fifo_full && !reset;
    assign fifo_push    = bus.lu_valid && bus.lu_ready;

    regfile_wr_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (LU_FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (fifo_push),
        .push_addr   (bus.lu_addr),
        .push_data   (bus.lu_data),
        .pop         (grant_b),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // The counter only grows while the head is denied, so reaching the
    // limit implies the FIFO is still occupied on the following cycle.
    always_comb begin
        state_next = state;
        case (state)
            ARB_NORMAL: if (starve_next == LIMIT) state_next = ARB_FORCE;
            ARB_FORCE:  state_next = ARB_NORMAL;
            default:    state_next = ARB_NORMAL;
        endcase
    end

    always_comb begin
        force_b      = (state == ARB_FORCE) && !fifo_empty;
        bus.wb_ready = !force_b;
        grant_a      = !force_b && bus.wb_valid;
        grant_b      = force_b || (!bus.wb_valid && !fifo_empty);
    end

    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || grant_b) begin
            starve_next = '0;
        end else if (grant_a && starve_cnt != LIMIT) begin
            starve_next = starve_cnt + 8'd1;
        end
    end

    // x0 writes are consumed like any other but never strobe the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else if (grant_a) begin
            wr_enable <= (bus.wb_addr != '0);
            wr_addr   <= bus.wb_addr;
            wr_data   <= bus.wb_data;
        end else if (grant_b) begin
            wr_enable <= (head_addr != '0);
            wr_addr   <= head_addr;
            wr_data   <= head_data;
        end else begin
            wr_enable <= 1'b0;
        end
    end

    always_comb begin
        pending_mask = '0;
        if (!reset) begin
            for (int i = 0; i < LU_FIFO_DEPTH; i++) begin
                if (entry_valid[i] && entry_addr[i] != '0) begin
                    pending_mask[entry_addr[i]] = 1'b1;
                end
            end
        end
    end

`ifdef REGWR_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_conflicts <= '0;
            stat_forced    <= '0;
        end else begin
            if (bus.wb_valid && !fifo_empty && stat_conflicts != 16'hFFFF) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
            if (force_b && stat_forced != 16'hFFFF) begin
                stat_forced <= stat_forced + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] pending_mask;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_enable;
`ifdef REGWR_ARB_STATS_EN
    logic [15:0] stat_conflicts;
    logic [15:0] stat_forced;
`endif

    int total;
    int bad;

    regfile_wr_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wr_arbiter #(
        .DATA_W        (32),
        .ADDR_W        (5),
        .LU_FIFO_DEPTH (4),
        .STARVE_LIMIT  (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .pending_mask   (pending_mask),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
`ifdef REGWR_ARB_STATS_EN
        .wr_enable      (wr_enable),
        .stat_conflicts (stat_conflicts),
        .stat_forced    (stat_forced)
`else
        .wr_enable      (wr_enable)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] drain_addrs [4];
        total = 0;
        bad   = 0;
        drain_addrs[0] = 5'd3;
        drain_addrs[1] = 5'd4;
        drain_addrs[2] = 5'd6;
        drain_addrs[3] = 5'd7;

        reset        = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.lu_valid = 1'b1;
        bus.lu_addr  = 5'd2;
        bus.lu_data  = 32'h2222;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_wr_enable", wr_enable, 0);
            check("rst_mask", pending_mask, 0);
            check("rst_lu_ready", bus.lu_ready, 0);
        end
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        reset        = 1'b0;
        bus.lu_valid = 1'b0;
        #1;
        check("post_rst_lu_ready", bus.lu_ready, 1);

        // A alone
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd5;
        bus.wb_data  = 32'hDEADBEEF;
        #1;
        check("a_wb_ready", bus.wb_ready, 1);
        tick();
        check("a_wr_enable", wr_enable, 1);
        check("a_wr_addr", wr_addr, 5);
        check("a_wr_data", wr_data, 32'hDEADBEEF);
        bus.wb_valid = 1'b0;
        tick();
        check("idle_wr_enable", wr_enable, 0);
        check("idle_wr_addr_hold", wr_addr, 5);

        // B minimum latency, no bypass of empty FIFO
        bus.lu_valid = 1'b1;
        bus.lu_addr  = 5'd12;
        bus.lu_data  = 32'hC0C0;
        tick();
        check("b_lat_first_cycle", wr_enable, 0);
        check("b_lat_mask", pending_mask, 32'h0000_1000);
        bus.lu_valid = 1'b0;
        tick();
        check("b_lat_wr_enable", wr_enable, 1);
        check("b_lat_wr_addr", wr_addr, 12);
        check("b_lat_mask_clear", pending_mask, 0);

        // Fill while A busy
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd10;
        bus.wb_data  = 32'hAAAA;
        for (int i = 0; i < 4; i++) begin
            bus.lu_valid = 1'b1;
            bus.lu_addr  = drain_addrs[i];
            bus.lu_data  = 32'h100 * drain_addrs[i];
            tick();
            check("fill_a_write", wr_addr, 10);
        end
        check("fill_lu_ready", bus.lu_ready, 0);
        check("fill_mask", pending_mask, 32'h0000_00D8);

        // Full: an offered entry is refused even though a dequeue happens now
        bus.wb_valid = 1'b0;
        bus.lu_addr  = 5'd8;
        bus.lu_data  = 32'h800;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.lu_valid = 1'b0;
            check("drain_wr_enable", wr_enable, 1);
            check("drain_wr_addr", wr_addr, drain_addrs[i]);
            check("drain_wr_data", wr_data, 32'h100 * drain_addrs[i]);
        end
        check("drain_mask", pending_mask, 0);
        tick();
        check("drain_no_extra", wr_enable, 0);

        // Starvation
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd1;
        bus.wb_data  = 32'h1111;
        bus.lu_valid = 1'b1;
        bus.lu_addr  = 5'd9;
        bus.lu_data  = 32'h9999;
        tick();
        bus.lu_valid = 1'b0;
        check("starve_mask", pending_mask, 32'h0000_0200);
        for (int i = 0; i < 8; i++) begin
            check("starve_wb_ready_hi", bus.wb_ready, 1);
            tick();
            check("starve_a_write", wr_addr, 1);
        end
        check("starve_wb_ready_lo", bus.wb_ready, 0);
        tick();
        check("starve_b_wr_enable", wr_enable, 1);
        check("starve_b_wr_addr", wr_addr, 9);
        check("starve_b_wr_data", wr_data, 32'h9999);
        check("starve_wb_ready_back", bus.wb_ready, 1);
        check("starve_mask_clear", pending_mask, 0);
        bus.wb_valid = 1'b0;
        tick();

        // x0 from B then from A
        bus.lu_valid = 1'b1;
        bus.lu_addr  = 5'd0;
        bus.lu_data  = 32'h5555;
        tick();
        bus.lu_valid = 1'b0;
        check("x0_b_mask", pending_mask, 0);
        tick();
        check("x0_b_wr_enable", wr_enable, 0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 32'h6666;
        #1;
        check("x0_a_wb_ready", bus.wb_ready, 1);
        tick();
        check("x0_a_wr_enable", wr_enable, 0);

        // Mid-operation reset with three queued entries
        bus.wb_addr = 5'd2;
        for (int i = 0; i < 3; i++) begin
            bus.lu_valid = 1'b1;
            bus.lu_addr  = 5'(20 + i);
            bus.lu_data  = 32'hF00 + 32'(i);
            tick();
        end
        check("mid_mask", pending_mask, 32'h0070_0000);
        bus.lu_valid = 1'b0;
        bus.wb_valid = 1'b0;
        reset        = 1'b1;
        tick();
        check("mid_rst_wr_enable", wr_enable, 0);
        check("mid_rst_mask", pending_mask, 0);
`ifdef REGWR_ARB_STATS_EN
        check("mid_rst_conflicts", stat_conflicts, 0);
        check("mid_rst_forced", stat_forced, 0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_write", wr_enable, 0);
            check("mid_mask_zero", pending_mask, 0);
        end
        check("mid_lu_ready", bus.lu_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
